// File: rtl/ir_rx_nec_decoder.sv
`timescale 1ns/1ps
// NEC IR frame receiver: synchronises and deglitches ir_rx_n, times marks and
// spaces in quarter-unit ticks, decodes frames/repeats into a valid/ack output.
module ir_rx_nec_decoder #(
  parameter int unsigned PRESCALE  = 1688,
  parameter bit          CHECK_INV = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ir_rx_n,
  input  logic        ir_tx_busy,
  input  logic        rx_ack,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic        rx_repeat,
  output logic        rx_ovf,
  output logic        rx_err,
  output logic        rx_busy
);

  localparam int unsigned   PW      = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_mark;
  logic [PW-1:0] r_pre;
  logic          w_tick;
  logic          w_blank;
  logic          r_filt;
  logic [1:0]    r_agree;
  logic          w_fedge;
  logic [6:0]    r_cnt;
  logic [6:0]    w_len;

  state_t        r_state;
  logic [4:0]    r_bitcnt;
  logic [31:0]   r_shreg;
  logic          r_rep;
  logic          r_err;
  logic          r_busy;

  logic [15:0]   r_last;
  logic          r_last_vld;
  logic          r_valid;
  logic [15:0]   r_data;
  logic          r_repeat;
  logic          r_ovf;

  logic          w_win_lead_mark;
  logic          w_win_lead_frame;
  logic          w_win_lead_rep;
  logic          w_win_short;
  logic          w_win_long;
  logic          w_stop_end;
  logic          w_inv_ok;
  logic          w_frame_ok;
  logic          w_frame_bad;
  logic          w_rep_ok;
  logic          w_deliver;
  logic [15:0]   w_dlv_data;

  assign w_blank = !en || ir_tx_busy;
  assign w_mark  = ~r_sync2;
  assign w_tick  = (r_pre == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ir_rx_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Filtered level flips on the third consecutive disagreeing tick sample.
  assign w_fedge = w_tick && (w_mark != r_filt) && (r_agree == 2'd2);

  always_ff @(posedge clk) begin
    if (rst || w_blank) begin
      r_filt  <= 1'b0;
      r_agree <= '0;
    end else if (w_tick) begin
      if (w_mark == r_filt) begin
        r_agree <= '0;
      end else if (r_agree == 2'd2) begin
        r_filt  <= w_mark;
        r_agree <= '0;
      end else begin
        r_agree <= r_agree + 2'd1;
      end
    end
  end

  // w_len counts the current tick, so at an edge it equals the full segment length.
  assign w_len = (r_cnt == 7'd127) ? 7'd127 : r_cnt + 7'd1;

  always_ff @(posedge clk) begin
    if (rst || w_blank) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= w_fedge ? '0 : w_len;
    end
  end

  assign w_win_lead_mark  = (w_len >= 7'd56) && (w_len <= 7'd72);
  assign w_win_lead_frame = (w_len >= 7'd28) && (w_len <= 7'd36);
  assign w_win_lead_rep   = (w_len >= 7'd14) && (w_len <= 7'd20);
  assign w_win_short      = (w_len >= 7'd2)  && (w_len <= 7'd6);
  assign w_win_long       = (w_len >= 7'd7)  && (w_len <= 7'd14);

  // Completion is resolved in the stop-mark end cycle itself, so delivery
  // and the inverse check need no separate state.
  assign w_stop_end  = !w_blank && w_fedge && (r_state == S_STOP_MARK) && w_win_short;
  assign w_inv_ok    = (r_shreg[15:8] == ~r_shreg[7:0]) && (r_shreg[31:24] == ~r_shreg[23:16]);
  assign w_frame_ok  = w_stop_end && !r_rep && (!CHECK_INV || w_inv_ok);
  assign w_frame_bad = w_stop_end && !r_rep && CHECK_INV && !w_inv_ok;
  assign w_rep_ok    = w_stop_end && r_rep && r_last_vld;
  assign w_deliver   = w_frame_ok || w_rep_ok;
  assign w_dlv_data  = r_rep ? r_last : {r_shreg[23:16], r_shreg[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_rep    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_blank) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else if (w_tick && w_fedge) begin
        case (r_state)
          S_IDLE: begin
            if (w_mark) begin
              r_state <= S_LEAD_MARK;
              r_busy  <= 1'b1;
            end
          end
          S_LEAD_MARK: begin
            if (w_win_lead_mark) begin
              r_state <= S_LEAD_SPACE;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          S_LEAD_SPACE: begin
            if (w_win_lead_frame) begin
              r_state  <= S_BIT_MARK;
              r_bitcnt <= '0;
              r_rep    <= 1'b0;
            end else if (w_win_lead_rep) begin
              r_state <= S_STOP_MARK;
              r_rep   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          S_BIT_MARK: begin
            if (w_win_short) begin
              r_state <= S_BIT_SPACE;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          S_BIT_SPACE: begin
            if (w_win_short || w_win_long) begin
              r_shreg  <= {w_win_long, r_shreg[31:1]};
              r_bitcnt <= r_bitcnt + 5'd1;
              r_state  <= (r_bitcnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
          S_STOP_MARK: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= !w_win_short || w_frame_bad;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_tick && (r_state != S_IDLE) && (w_len == 7'd127)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (!en) begin
      r_last_vld <= 1'b0;
    end else if (w_frame_ok) begin
      r_last     <= w_dlv_data;
      r_last_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_repeat <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_deliver) begin
      if (!r_valid || rx_ack) begin
        r_valid  <= 1'b1;
        r_data   <= w_dlv_data;
        r_repeat <= r_rep;
        r_ovf    <= 1'b0;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (r_valid && rx_ack) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign rx_valid  = r_valid;
  assign rx_data   = r_data;
  assign rx_repeat = r_repeat;
  assign rx_ovf    = r_ovf;
  assign rx_err    = r_err;
  assign rx_busy   = r_busy;

endmodule
